// File: rtl/trap_ctrl.sv
// Trap/return sequencer feeding the CSR exception-update bus, with pipeline stall, flush and redirect control.
// Optional build macro IRQ_SYNC_EN: route meip/mtip/msip through 2-flop synchronisers.
//
// state | meaning
// IDLE  | sampling the committing instruction for interrupt / exception / MRET
// TRAP  | CSR write of mepc/mcause/mtval/mstatus, pipeline flushed
// RET   | CSR mstatus restore for MRET, pipeline flushed
// REDIR | one-cycle PC redirect from exc_ret_addr
module trap_ctrl #(
    parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] mem_addr_i,
    input  logic        e_illegal_i,
    input  logic        e_inst_mis_i,
    input  logic        e_ecall_i,
    input  logic        e_ebreak_i,
    input  logic        e_st_mis_i,
    input  logic        e_ld_mis_i,
    input  logic        is_mret_i,
    input  logic        meip_i,
    input  logic        mtip_i,
    input  logic        msip_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mie_i,
    output logic        we_exc_o,
    output logic [31:0] mcause_d_o,
    output logic [31:0] mepc_d_o,
    output logic [31:0] mtval_d_o,
    output logic [31:0] mstatus_d_o,
    output logic [31:0] mip_d_o,
    output logic        is_int_o,
    output logic        sel_exc_nret_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic        redirect_o
);

    typedef enum logic [1:0] {IDLE, TRAP, RET, REDIR} state_t;

    state_t      state, state_nxt;
    logic [2:0]  irq_lines;     // {meip, mtip, msip}
    logic        post_rst;
    logic [31:0] mstatus_cur;
    logic [2:0]  irq_pend;
    logic        exc_any;
    logic        take_irq, take_exc, take_ret;
    logic [31:0] cause_sel, tval_sel, mstatus_trap, mstatus_ret;

    logic [31:0] mcause_q, mepc_q, mtval_q, mstatus_q, mip_q;
    logic        is_int_q, sel_q;

    logic        we_exc, flush, stall, redirect, sel_out, is_int;

`ifdef IRQ_SYNC_EN
    logic [2:0] sync1, sync2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
        end else begin
            sync1 <= {meip_i, mtip_i, msip_i};
            sync2 <= sync1;
        end
    end

    assign irq_lines = sync2;
`else
    assign irq_lines = {meip_i, mtip_i, msip_i};
`endif

    // The CSR file is itself in reset during the cycle after rst_i drops.
    always_ff @(posedge clk_i) begin
        post_rst <= rst_i;
    end

    assign mstatus_cur = post_rst ? RESET_MSTATUS : mstatus_i;
    assign irq_pend    = irq_lines & {mie_i[11], mie_i[7], mie_i[3]} & {3{mstatus_cur[3]}};
    assign exc_any     = e_illegal_i | e_inst_mis_i | e_ecall_i | e_ebreak_i | e_st_mis_i | e_ld_mis_i;
    assign take_irq    = valid_i & (|irq_pend);
    assign take_exc    = valid_i & exc_any & ~take_irq;
    assign take_ret    = valid_i & is_mret_i & ~exc_any & ~take_irq;

    always_comb begin
        cause_sel = 32'h0;
        tval_sel  = 32'h0;
        if (take_irq) begin
            if (irq_pend[2])      cause_sel = 32'h8000_000B;
            else if (irq_pend[0]) cause_sel = 32'h8000_0003;
            else                  cause_sel = 32'h8000_0007;
        end else if (e_illegal_i) begin
            cause_sel = 32'd2;
            tval_sel  = inst_i;
        end else if (e_inst_mis_i) begin
            cause_sel = 32'd0;
            tval_sel  = mem_addr_i;
        end else if (e_ecall_i) begin
            cause_sel = 32'd11;
        end else if (e_ebreak_i) begin
            cause_sel = 32'd3;
            tval_sel  = pc_i;
        end else if (e_st_mis_i) begin
            cause_sel = 32'd6;
            tval_sel  = mem_addr_i;
        end else if (e_ld_mis_i) begin
            cause_sel = 32'd4;
            tval_sel  = mem_addr_i;
        end
    end

    always_comb begin
        mstatus_trap        = mstatus_cur;
        mstatus_trap[7]     = mstatus_cur[3];
        mstatus_trap[3]     = 1'b0;
        mstatus_trap[12:11] = 2'b11;
        mstatus_ret         = mstatus_cur;
        mstatus_ret[3]      = mstatus_cur[7];
        mstatus_ret[7]      = 1'b1;
        mstatus_ret[12:11]  = 2'b11;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            mcause_q  <= 32'h0;
            mepc_q    <= 32'h0;
            mtval_q   <= 32'h0;
            mstatus_q <= 32'h0;
            mip_q     <= 32'h0;
            is_int_q  <= 1'b0;
            sel_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (take_irq || take_exc)) begin
                mcause_q  <= cause_sel;
                mepc_q    <= pc_i;
                mtval_q   <= tval_sel;
                mstatus_q <= mstatus_trap;
                mip_q     <= {20'b0, irq_lines[2], 3'b0, irq_lines[1], 3'b0, irq_lines[0], 3'b0};
                is_int_q  <= take_irq;
                sel_q     <= 1'b0;
            end else if (state == IDLE && take_ret) begin
                mstatus_q <= mstatus_ret;
                is_int_q  <= 1'b0;
                sel_q     <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        we_exc    = 1'b0;
        flush     = 1'b0;
        stall     = 1'b0;
        redirect  = 1'b0;
        sel_out   = 1'b0;
        is_int    = 1'b0;
        case (state)
            IDLE: begin
                if (take_irq || take_exc) begin
                    state_nxt = TRAP;
                    stall     = 1'b1;
                end else if (take_ret) begin
                    state_nxt = RET;
                    stall     = 1'b1;
                end
            end
            TRAP: begin
                state_nxt = REDIR;
                we_exc    = 1'b1;
                flush     = 1'b1;
                stall     = 1'b1;
                is_int    = is_int_q;
            end
            RET: begin
                state_nxt = REDIR;
                we_exc    = 1'b1;
                flush     = 1'b1;
                stall     = 1'b1;
                sel_out   = 1'b1;
            end
            REDIR: begin
                state_nxt = IDLE;
                redirect  = 1'b1;
                stall     = 1'b1;
                sel_out   = sel_q;
                is_int    = is_int_q;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are suppressed in a reset cycle so the CSR file never sees a partial update.
    assign we_exc_o       = we_exc & ~rst_i;
    assign flush_o        = flush & ~rst_i;
    assign stall_o        = stall & ~rst_i;
    assign redirect_o     = redirect & ~rst_i;
    assign sel_exc_nret_o = sel_out & ~rst_i;
    assign is_int_o       = is_int & ~rst_i;
    assign mcause_d_o     = mcause_q;
    assign mepc_d_o       = mepc_q;
    assign mtval_d_o      = mtval_q;
    assign mstatus_d_o    = mstatus_q;
    assign mip_d_o        = mip_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed testbench for trap_ctrl: reset, trap/return sequencing, priorities, masking and reset abort.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] pc, inst, mem_addr;
    logic        e_illegal, e_inst_mis, e_ecall, e_ebreak, e_st_mis, e_ld_mis;
    logic        is_mret, meip, mtip, msip;
    logic [31:0] mstatus, mie;
    logic        we_exc, is_int, sel_exc_nret, stall, flush, redirect;
    logic [31:0] mcause_d, mepc_d, mtval_d, mstatus_d, mip_d;

    int vec = 0;
    int errs = 0;

    trap_ctrl dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .pc_i(pc), .inst_i(inst),
        .mem_addr_i(mem_addr), .e_illegal_i(e_illegal), .e_inst_mis_i(e_inst_mis),
        .e_ecall_i(e_ecall), .e_ebreak_i(e_ebreak), .e_st_mis_i(e_st_mis),
        .e_ld_mis_i(e_ld_mis), .is_mret_i(is_mret), .meip_i(meip), .mtip_i(mtip),
        .msip_i(msip), .mstatus_i(mstatus), .mie_i(mie), .we_exc_o(we_exc),
        .mcause_d_o(mcause_d), .mepc_d_o(mepc_d), .mtval_d_o(mtval_d),
        .mstatus_d_o(mstatus_d), .mip_d_o(mip_d), .is_int_o(is_int),
        .sel_exc_nret_o(sel_exc_nret), .stall_o(stall), .flush_o(flush),
        .redirect_o(redirect)
    );

    always #5 clk = ~clk;

    task automatic clear_events();
        valid = 0; e_illegal = 0; e_inst_mis = 0; e_ecall = 0; e_ebreak = 0;
        e_st_mis = 0; e_ld_mis = 0; is_mret = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; clear_events();
        pc = 0; inst = 0; mem_addr = 0; meip = 0; mtip = 0; msip = 0;
        mstatus = 0; mie = 0;
        repeat (3) step();
        vec++;
        if ({we_exc, is_int, sel_exc_nret, stall, flush, redirect} !== 6'b0) begin
            errs++; $display("FAIL reset_strobes got %b want 000000",
                             {we_exc, is_int, sel_exc_nret, stall, flush, redirect});
        end
        vec++;
        if ({mcause_d, mepc_d, mtval_d, mstatus_d, mip_d} !== 160'h0) begin
            errs++; $display("FAIL reset_data got %h %h %h %h %h want 0",
                             mcause_d, mepc_d, mtval_d, mstatus_d, mip_d);
        end
        rst = 0;
        repeat (2) step();
    endtask

    task automatic test_illegal();
        @(negedge clk);
        valid = 1; e_illegal = 1; pc = 32'h100; inst = 32'hFFFF_FFFF; mstatus = 32'h0;
        #1;
        vec++;
        if (stall !== 1'b1) begin errs++; $display("FAIL ill_detect_stall got %b want 1", stall); end
        step(); clear_events();
        vec++;
        if ({we_exc, flush, stall, sel_exc_nret, is_int, redirect} !== 6'b111000) begin
            errs++; $display("FAIL ill_trap_strobes got %b want 111000",
                             {we_exc, flush, stall, sel_exc_nret, is_int, redirect});
        end
        vec++;
        if (mcause_d !== 32'd2 || mepc_d !== 32'h100 || mtval_d !== 32'hFFFF_FFFF) begin
            errs++; $display("FAIL ill_trap_data got %h %h %h want 2 100 ffffffff",
                             mcause_d, mepc_d, mtval_d);
        end
        vec++;
        if (mstatus_d !== 32'h1800) begin
            errs++; $display("FAIL ill_mstatus got %h want 00001800", mstatus_d);
        end
        step();
        vec++;
        if ({redirect, stall, we_exc, flush} !== 4'b1100) begin
            errs++; $display("FAIL ill_redir got %b want 1100", {redirect, stall, we_exc, flush});
        end
        step();
        vec++;
        if ({redirect, stall, we_exc} !== 3'b000 || mcause_d !== 32'd2) begin
            errs++; $display("FAIL ill_idle got %b %h want 000 2", {redirect, stall, we_exc}, mcause_d);
        end
    endtask

    task automatic test_irq_priority();
        @(negedge clk);
        valid = 1; e_ecall = 1; pc = 32'h200; mstatus = 32'h8; mie = 32'h800; meip = 1;
        step(); clear_events(); meip = 0;
        vec++;
        if (mcause_d !== 32'h8000_000B || is_int !== 1'b1 || we_exc !== 1'b1) begin
            errs++; $display("FAIL irq_mei got %h %b %b want 8000000b 1 1", mcause_d, is_int, we_exc);
        end
        vec++;
        if (mstatus_d !== 32'h1880 || mepc_d !== 32'h200 || mip_d !== 32'h800) begin
            errs++; $display("FAIL irq_mei_data got %h %h %h want 1880 200 800", mstatus_d, mepc_d, mip_d);
        end
        repeat (2) step();
        @(negedge clk);
        valid = 1; pc = 32'h210; mie = 32'h888; msip = 1; mtip = 1;
        step(); clear_events(); msip = 0; mtip = 0;
        vec++;
        if (mcause_d !== 32'h8000_0003 || mip_d !== 32'h88) begin
            errs++; $display("FAIL irq_msi_over_mti got %h %h want 80000003 88", mcause_d, mip_d);
        end
        repeat (2) step();
    endtask

    task automatic test_irq_mask();
        @(negedge clk);
        valid = 1; pc = 32'h300; mstatus = 32'h0; mie = 32'h80; mtip = 1;
        #1;
        vec++;
        if (stall !== 1'b0) begin errs++; $display("FAIL mask_stall got %b want 0", stall); end
        step();
        vec++;
        if (we_exc !== 1'b0) begin errs++; $display("FAIL mask_we got %b want 0", we_exc); end
        @(negedge clk);
        mstatus = 32'h8;
        #1;
        vec++;
        if (stall !== 1'b1) begin errs++; $display("FAIL unmask_stall got %b want 1", stall); end
        step(); clear_events(); mtip = 0;
        vec++;
        if (mcause_d !== 32'h8000_0007 || is_int !== 1'b1) begin
            errs++; $display("FAIL unmask_mti got %h %b want 80000007 1", mcause_d, is_int);
        end
        repeat (2) step();
    endtask

    task automatic test_exc_priority();
        logic [5:0]  ev    [4] = '{6'b001100, 6'b000100, 6'b100010, 6'b011001};
        logic [31:0] pcs   [4] = '{32'h400, 32'h404, 32'h40C, 32'h408};
        logic [31:0] cause [4] = '{32'd11, 32'd3, 32'd2, 32'd0};
        logic [31:0] tval  [4] = '{32'h0, 32'h404, 32'h0000_DEAD, 32'h82};
        mstatus = 32'h0; mie = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            valid = 1; pc = pcs[i]; inst = 32'h0000_DEAD; mem_addr = 32'h82;
            {e_illegal, e_inst_mis, e_ecall, e_ebreak, e_st_mis, e_ld_mis} = ev[i];
            step(); clear_events();
            vec++;
            if (we_exc !== 1'b1 || mcause_d !== cause[i] || mtval_d !== tval[i] || mepc_d !== pcs[i]) begin
                errs++; $display("FAIL exc_prio[%0d] got %b %h %h %h want 1 %h %h %h", i,
                                 we_exc, mcause_d, mtval_d, mepc_d, cause[i], tval[i], pcs[i]);
            end
            repeat (2) step();
        end
    endtask

    task automatic test_mret();
        @(negedge clk);
        valid = 1; is_mret = 1; pc = 32'h500; mstatus = 32'h1880;
        #1;
        vec++;
        if (stall !== 1'b1) begin errs++; $display("FAIL mret_stall got %b want 1", stall); end
        step(); clear_events();
        vec++;
        if ({we_exc, flush, sel_exc_nret, is_int} !== 4'b1110 || mstatus_d !== 32'h1888) begin
            errs++; $display("FAIL mret_ret got %b %h want 1110 1888",
                             {we_exc, flush, sel_exc_nret, is_int}, mstatus_d);
        end
        vec++;
        if (mcause_d !== 32'd0 || mepc_d !== 32'h408 || mtval_d !== 32'h82) begin
            errs++; $display("FAIL mret_hold got %h %h %h want 0 408 82", mcause_d, mepc_d, mtval_d);
        end
        step();
        vec++;
        if ({redirect, sel_exc_nret, we_exc} !== 3'b110) begin
            errs++; $display("FAIL mret_redir got %b want 110", {redirect, sel_exc_nret, we_exc});
        end
        step();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        valid = 1; e_ld_mis = 1; e_st_mis = 1; mem_addr = 32'h203; pc = 32'h600; mstatus = 32'h0;
        step();
        clear_events();
        valid = 1; e_ecall = 1; pc = 32'h604;
        vec++;
        if (mcause_d !== 32'd6 || mtval_d !== 32'h203) begin
            errs++; $display("FAIL ldst got %h %h want 6 203", mcause_d, mtval_d);
        end
        step(); clear_events();
        vec++;
        if (redirect !== 1'b1 || mcause_d !== 32'd6 || mepc_d !== 32'h600) begin
            errs++; $display("FAIL ignore_redir got %b %h %h want 1 6 600", redirect, mcause_d, mepc_d);
        end
        step();
        vec++;
        if (we_exc !== 1'b0 || stall !== 1'b0 || mcause_d !== 32'd6) begin
            errs++; $display("FAIL ignore_idle got %b %b %h want 0 0 6", we_exc, stall, mcause_d);
        end
    endtask

    task automatic test_valid_low();
        @(negedge clk);
        valid = 0; e_illegal = 1; pc = 32'h700;
        #1;
        vec++;
        if (stall !== 1'b0) begin errs++; $display("FAIL vlow_stall got %b want 0", stall); end
        step(); clear_events();
        vec++;
        if (we_exc !== 1'b0 || mepc_d !== 32'h600) begin
            errs++; $display("FAIL vlow_we got %b %h want 0 600", we_exc, mepc_d);
        end
    endtask

    task automatic test_reset_in_trap();
        @(negedge clk);
        valid = 1; e_illegal = 1; pc = 32'h800; inst = 32'h1234;
        step(); clear_events();
        rst = 1;
        #1;
        vec++;
        if (we_exc !== 1'b0 || flush !== 1'b0) begin
            errs++; $display("FAIL rst_trap_gate got %b %b want 0 0", we_exc, flush);
        end
        step();
        vec++;
        if ({we_exc, flush, stall, redirect, sel_exc_nret, is_int} !== 6'b0 ||
            mcause_d !== 32'h0 || mepc_d !== 32'h0 || mtval_d !== 32'h0 || mstatus_d !== 32'h0) begin
            errs++; $display("FAIL rst_trap got %b %h %h %h %h want 0",
                             {we_exc, flush, stall, redirect, sel_exc_nret, is_int},
                             mcause_d, mepc_d, mtval_d, mstatus_d);
        end
        rst = 0;
        step();
        vec++;
        if (stall !== 1'b0 || redirect !== 1'b0) begin
            errs++; $display("FAIL rst_trap_after got %b %b want 0 0", stall, redirect);
        end
        repeat (2) step();
    endtask

    task automatic test_irq_latency();
        int cycles = 0;
        int want;
        bit seen = 0;
`ifdef IRQ_SYNC_EN
        want = 3;
`else
        want = 1;
`endif
        @(negedge clk);
        valid = 1; pc = 32'h900; mstatus = 32'h8; mie = 32'h800; meip = 1;
        while (!seen && cycles < 10) begin
            step();
            cycles++;
            if (we_exc === 1'b1) seen = 1;
        end
        clear_events(); meip = 0;
        vec++;
        if (!seen || cycles != want) begin
            errs++; $display("FAIL irq_latency got %0d (seen=%0d) want %0d", cycles, seen, want);
        end
        vec++;
        if (mcause_d !== 32'h8000_000B || mepc_d !== 32'h900) begin
            errs++; $display("FAIL irq_latency_data got %h %h want 8000000b 900", mcause_d, mepc_d);
        end
        repeat (4) step();
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_irq_priority();
        test_irq_mask();
        test_exc_priority();
        test_mret();
        test_back_to_back();
        test_valid_low();
        test_reset_in_trap();
        test_irq_latency();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
